// File: rtl/hilo_divide_unit_if.sv
// Request/result bundle between the Execute stage and the HI/LO divide unit.
// master: the requesting pipeline stage; slave: the divider.
interface hilo_divide_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             abort;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, abort, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, abort, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/hilo_divide_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Quotient feeds LO,
// remainder feeds HI. Signs are stripped on capture and restored in FIX.
// Optional feature macro: DIV_EARLY_OUT_EN (skip the iteration when the
// divisor magnitude exceeds the dividend magnitude).
module hilo_divide_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    hilo_divide_unit_if.slave  div
);
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;     // shifts dividend out, quotient bits in
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder, always < divisor
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic             fits;

    assign a_neg = div.is_signed & div.dividend[WIDTH-1];
    assign b_neg = div.is_signed & div.divisor[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
    assign a_mag = a_neg ? -div.dividend : div.dividend;
    assign b_mag = b_neg ? -div.divisor  : div.divisor;

    // WIDTH+1-bit trial value so a top-bit shift-in never overflows the compare
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign fits    = shifted >= {1'b0, dvsr_q};

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (div.start && !div.abort) begin
                    quo_d     = a_mag;
                    dvsr_d    = b_mag;
                    rem_d     = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (div.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = div.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
`ifdef DIV_EARLY_OUT_EN
                    end else if (b_mag > a_mag) begin
                        quotient_d  = '0;
                        remainder_d = div.dividend;
                        dbz_d       = 1'b0;
                        state_d     = DONE;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (div.abort) begin
                    state_d = IDLE;
                end else begin
                    // Remainder result is < divisor, so the top bit is always zero
                    rem_d = fits ? WIDTH'(shifted - {1'b0, dvsr_q}) : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], fits};
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FIX: begin
                if (div.abort) begin
                    state_d = IDLE;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            default: begin
                // DONE: result already committed, abort has no effect here
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign div.busy        = (state_q != IDLE);
    assign div.done        = (state_q == DONE);
    assign div.quotient    = quotient_q;
    assign div.remainder   = remainder_q;
    assign div.div_by_zero = dbz_q;
endmodule

// File: tb/tb_hilo_divide_unit.sv
// Self-checking bench for hilo_divide_unit: directed cases, abort/reset
// scenarios and randomized requests against an arithmetic reference model.
module tb_hilo_divide_unit;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    hilo_divide_unit_if #(.WIDTH(WIDTH)) dif ();

    hilo_divide_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (dif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: divide with the language's truncating signed/unsigned operators
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        longint sa, sb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        if (b == 32'd0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    function automatic int latency(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        ma = s ? longint'($signed(a)) : longint'(a);
        mb = s ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`endif
        return WIDTH + 2;
    endfunction

    // Entered and left just after a rising edge; the Start cycle is cycle 0
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        int          lat, cyc;
        bit          busy_ok;
        model(s, a, b, eq, er, ez);
        lat = latency(s, a, b);
        dif.start = 1'b1; dif.is_signed = s; dif.dividend = a; dif.divisor = b;
        @(posedge clk); #1;
        dif.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!dif.done && cyc < 100) begin
            if (!dif.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
            @(negedge clk);
        end
        check({tag, ":latency"}, 64'(cyc), 64'(lat));
        check({tag, ":busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, ":busy_at_done"}, 64'(dif.busy), 64'd1);
        check({tag, ":quotient"}, 64'(dif.quotient), 64'(eq));
        check({tag, ":remainder"}, 64'(dif.remainder), 64'(er));
        check({tag, ":dbz"}, 64'(dif.div_by_zero), 64'(ez));
        @(posedge clk); #1;
        check({tag, ":idle_after"}, 64'({dif.busy, dif.done}), 64'd0);
        check({tag, ":held_q"}, 64'(dif.quotient), 64'(eq));
    endtask

    initial begin
        logic [31:0] last_q;
        bit          saw_done;
        dif.start = 1'b0; dif.is_signed = 1'b0; dif.abort = 1'b0;
        dif.dividend = '0; dif.divisor = '0;
        #3;
        check("reset_busy", 64'(dif.busy), 64'd0);
        check("reset_done", 64'(dif.done), 64'd0);
        check("reset_q", 64'(dif.quotient), 64'd0);
        check("reset_r", 64'(dif.remainder), 64'd0);
        check("reset_dbz", 64'(dif.div_by_zero), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_55_0", 1'b0, 32'd55, 32'd0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10);
        run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);

        // Abort mid-divide with a concurrent, ignored Start
        last_q = 32'hFFFF_FFFF;
        saw_done = 1'b0;
        dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (dif.done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        dif.abort = 1'b1; dif.start = 1'b1; dif.dividend = 32'd9; dif.divisor = 32'd3;
        @(posedge clk); #1;
        dif.abort = 1'b0; dif.start = 1'b0;
        check("abort_busy_c11", 64'(dif.busy), 64'd0);
        check("abort_no_done", 64'({saw_done, dif.done}), 64'd0);
        check("abort_q_held", 64'(dif.quotient), 64'(last_q));
        check("abort_dbz_held", 64'(dif.div_by_zero), 64'd1);
        @(posedge clk); #1;
        check("abort_ignored_c12", 64'(dif.busy), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // Abort and Start together in IDLE: request dropped
        dif.abort = 1'b1; dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
        @(posedge clk); #1;
        dif.abort = 1'b0; dif.start = 1'b0;
        check("idle_abort_busy", 64'(dif.busy), 64'd0);
        @(posedge clk); #1;
        check("idle_abort_busy2", 64'(dif.busy), 64'd0);
        check("idle_abort_q", 64'(dif.quotient), 64'd3);

        // Randomized requests
        for (int i = 0; i < 24; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          mode;
            s = 1'($urandom_range(0, 1));
            a = (i % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            run_div($sformatf("rand%0d", i), s, a, b);
        end

        // Asynchronous reset mid-divide
        dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 64'(dif.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(dif.busy), 64'd0);
        check("rst_done", 64'(dif.done), 64'd0);
        check("rst_q", 64'(dif.quotient), 64'd0);
        check("rst_r", 64'(dif.remainder), 64'd0);
        check("rst_dbz", 64'(dif.div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
